// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin HC-SR04 ping scheduler with shared echo timing datapath
// Ports: clk, reset_p (sync, active-high), enable_mask/echo per sensor in; trig per sensor,
// distance_cm (16 bits per sensor), dist_valid pulse, sensor_id, timeout_flag, busy out.
// Optional echo timeout: define ULTRASONIC_SCHED_TIMEOUT_EN.
module ultrasonic_scheduler #(
  parameter int NUM_SENS   = 3,
  parameter int CLK_MHZ    = 100,
  parameter int GUARD_US   = 40000,
  parameter int TRIG_US    = 12,
  parameter int TIMEOUT_US = 30000
) (
  input  logic                    clk,
  input  logic                    reset_p,
  input  logic [NUM_SENS-1:0]     enable_mask,
  input  logic [NUM_SENS-1:0]     echo,
  output logic [NUM_SENS-1:0]     trig,
  output logic [16*NUM_SENS-1:0]  distance_cm,
  output logic                    dist_valid,
  output logic [2:0]              sensor_id,
  output logic [NUM_SENS-1:0]     timeout_flag,
  output logic                    busy
);
  typedef enum logic [2:0] {S_IDLE, S_GUARD, S_TRIG, S_WAIT_PEDGE, S_WAIT_NEDGE, S_DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_SENS-1:0] s1_q, s2_q, oh;
  logic [16*NUM_SENS-1:0] dist_q;
  logic [31:0] pre_q, us_q;
  logic [15:0] cm_q;
  logic [5:0] sub_q;
  logic [2:0] id_q, id_d;
  logic prev_q, first_q, valid_q, sel, rise, fall, tick, enter, timed_out;
  int base;
  assign oh = NUM_SENS'(1) << id_q;
  assign sel = |(s2_q & oh);
  assign rise = sel & ~prev_q;
  assign fall = ~sel & prev_q;
  assign tick = pre_q == 32'(CLK_MHZ - 1);
  assign enter = state_d != state_q;
  // after reset the search starts at index 0 inclusive, i.e. just after NUM_SENS-1
  assign base = first_q ? NUM_SENS - 1 : int'(id_q);
  always_comb begin
    id_d = id_q;
    for (int k = NUM_SENS; k >= 1; k--)
      if (|(enable_mask & (NUM_SENS'(1) << ((base + k) % NUM_SENS)))) id_d = 3'((base + k) % NUM_SENS);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = |enable_mask ? S_GUARD : S_IDLE;
      S_GUARD:      state_d = (tick && us_q == 32'(GUARD_US - 1)) ? S_TRIG : S_GUARD;
      S_TRIG:       state_d = (tick && us_q == 32'(TRIG_US - 1)) ? S_WAIT_PEDGE : S_TRIG;
      S_WAIT_PEDGE: state_d = rise ? S_WAIT_NEDGE : timed_out ? S_DONE : S_WAIT_PEDGE;
      S_WAIT_NEDGE: state_d = (fall || timed_out) ? S_DONE : S_WAIT_NEDGE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= 1'b0;
      pre_q   <= '0;
      us_q    <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      id_q    <= '0;
      first_q <= 1'b1;
      dist_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= echo;
      s2_q    <= s1_q;
      prev_q  <= sel;
      pre_q   <= (enter || tick) ? '0 : pre_q + 32'd1;
      us_q    <= enter ? '0 : us_q + 32'(tick);
      valid_q <= state_q == S_DONE;
      if (state_q == S_IDLE && |enable_mask) begin
        id_q    <= id_d;
        first_q <= 1'b0;
      end
      if (state_q == S_WAIT_PEDGE) begin
        sub_q <= '0;
        cm_q  <= '0;
      end else if (state_q == S_WAIT_NEDGE && tick) begin
        sub_q <= sub_q == 6'd57 ? 6'd0 : sub_q + 6'd1;
        if (sub_q == 6'd57 && cm_q != 16'hFFFF) cm_q <= cm_q + 16'd1;
      end
      if (timed_out) cm_q <= 16'hFFFF;
      if (state_q == S_DONE) dist_q[16*id_q +: 16] <= cm_q;
    end
  end
`ifdef ULTRASONIC_SCHED_TIMEOUT_EN
  logic [31:0] to_q;
  logic [NUM_SENS-1:0] tflag_q;
  logic tout_q;
  // a falling edge in the same cycle as expiry wins
  assign timed_out = tick && to_q == 32'(TIMEOUT_US - 1) &&
                     ((state_q == S_WAIT_PEDGE && !rise) || (state_q == S_WAIT_NEDGE && !fall));
  always_ff @(posedge clk) begin
    if (reset_p) begin
      to_q    <= '0;
      tout_q  <= 1'b0;
      tflag_q <= '0;
    end else begin
      to_q   <= state_q == S_TRIG ? '0 : to_q + 32'(tick);
      tout_q <= state_q == S_TRIG ? 1'b0 : tout_q | timed_out;
      if (state_q == S_DONE) tflag_q <= (tflag_q & ~oh) | (tout_q ? oh : '0);
    end
  end
  assign timeout_flag = tflag_q;
`else
  assign timed_out = 1'b0;
  assign timeout_flag = '0;
`endif
  assign trig = state_q == S_TRIG ? oh : '0;
  assign distance_cm = dist_q;
  assign dist_valid = valid_q;
  assign sensor_id = id_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler: directed scoreboard bench for ultrasonic_scheduler
module tb_ultrasonic_scheduler;
  localparam int N = 3;
  logic clk = 1'b0, reset_p = 1'b1;
  logic [N-1:0] enable_mask = '0, echo = '0;
  logic [N-1:0] trig, timeout_flag;
  logic [16*N-1:0] distance_cm;
  logic dist_valid, busy;
  logic [2:0] sensor_id;
  typedef struct {int id; logic [15:0] d; logic to;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errs = 0, chks = 0, vcnt = 0;
  always #5 clk = ~clk;
  ultrasonic_scheduler #(.NUM_SENS(N), .CLK_MHZ(10), .GUARD_US(100), .TRIG_US(12), .TIMEOUT_US(2000)) dut (
    .clk(clk), .reset_p(reset_p), .enable_mask(enable_mask), .echo(echo), .trig(trig),
    .distance_cm(distance_cm), .dist_valid(dist_valid), .sensor_id(sensor_id),
    .timeout_flag(timeout_flag), .busy(busy));
  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    chks++;
    assert (o === x) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, x);
    end
  endtask
  task automatic push(input int id, input int d, input logic to);
    exp_t t;
    t.id = id;
    t.d = 16'(d);
    t.to = to;
    sb.push_back(t);
  endtask
  always @(negedge clk) begin
    if (trig != '0) check("trig_onehot", 64'($onehot(trig)), 64'd1);
    if (dist_valid) begin
      vcnt++;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("dist_id", 64'(sensor_id), 64'(e.id));
        check("dist_val", 64'(distance_cm[16*e.id +: 16]), 64'(e.d));
        check("dist_toflag", 64'(timeout_flag[e.id]), 64'(e.to));
      end
    end
  end
  task automatic wait_trig(input int maxc, output int id, output int lat, output int w);
    logic [N-1:0] t;
    id = -1;
    lat = 0;
    w = 0;
    while (trig == '0 && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    check("trig_seen", 64'(trig != '0), 64'd1);
    if (trig == '0) return;
    t = trig;
    for (int i = 0; i < N; i++) if (t[i]) id = i;
    while (trig == t && w < 1000) begin
      @(negedge clk);
      w++;
    end
  endtask
  task automatic echo_pulse(input int ch, input int us);
    repeat (30) @(negedge clk);
    echo[ch] = 1'b1;
    repeat (us * 10) @(negedge clk);
    echo[ch] = 1'b0;
  endtask
  initial begin
    int id, lat, w, v0;
    int w_us[3] = '{580, 116, 57};
    int d_ex[3] = '{10, 2, 0};
    int seq[3] = '{2, 0, 2};
    repeat (3) @(negedge clk);
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_dist", 64'(distance_cm), 64'd0);
    check("rst_valid", 64'(dist_valid), 64'd0);
    check("rst_id", 64'(sensor_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_toflag", 64'(timeout_flag), 64'd0);
    reset_p = 1'b0;
    repeat (20) @(negedge clk);
    check("mask0_busy", 64'(busy), 64'd0);
    enable_mask = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wait_trig(3000, id, lat, w);
      check("rr_id", 64'(id), 64'(i));
      check("trig_width", 64'(w), 64'd120);
      push(i, d_ex[i], 1'b0);
      echo_pulse(i, w_us[i]);
    end
    repeat (20) @(negedge clk);
    check("round_valids", 64'(vcnt), 64'd3);
    check("round_dists", 64'(distance_cm), {16'd0, 16'd0, 16'd2, 16'd10});
    wait_trig(3000, id, lat, w);
    check("wrap_id", 64'(id), 64'd0);
    enable_mask = 3'b101;
    push(0, 1, 1'b0);
    echo_pulse(0, 58);
    for (int i = 0; i < 3; i++) begin
      wait_trig(3000, id, lat, w);
      check("m101_id", 64'(id), 64'(seq[i]));
      check("m101_width", 64'(w), 64'd120);
      if (i == 2) enable_mask = 3'b111;
      push(seq[i], 1, 1'b0);
      echo_pulse(seq[i], 58);
    end
    wait_trig(3000, id, lat, w);
    check("midmask_id", 64'(id), 64'd0);
    repeat (30) @(negedge clk);
    echo[0] = 1'b1;
    repeat (1000) @(negedge clk);
    enable_mask = 3'b010;
    repeat (740) @(negedge clk);
    push(0, 3, 1'b0);
    echo[0] = 1'b0;
    echo[1] = 1'b1;
    wait_trig(3000, id, lat, w);
    check("after_mask_id", 64'(id), 64'd1);
    repeat (200) @(negedge clk);
    echo[1] = 1'b0;
    repeat (200) @(negedge clk);
    push(1, 5, 1'b0);
    echo[1] = 1'b1;
    repeat (2900) @(negedge clk);
    echo[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("prehigh_dist", 64'(distance_cm[31:16]), 64'd5);
    check("midmask_dist", 64'(distance_cm[15:0]), 64'd3);
`ifdef ULTRASONIC_SCHED_TIMEOUT_EN
    wait_trig(3000, id, lat, w);
    check("to_id", 64'(id), 64'd1);
    push(1, 16'hFFFF, 1'b1);
    v0 = vcnt;
    lat = 0;
    while (vcnt == v0 && lat < 25000) begin
      @(negedge clk);
      lat++;
    end
    check("to_update", 64'(vcnt), 64'(v0 + 1));
    check("to_latency", 64'(lat >= 19990 && lat <= 20020), 64'd1);
    check("to_flag_set", 64'(timeout_flag[1]), 64'd1);
    wait_trig(3000, id, lat, w);
    check("to_next_id", 64'(id), 64'd1);
    push(1, 1, 1'b0);
    echo_pulse(1, 58);
    repeat (20) @(negedge clk);
    check("to_flag_clr", 64'(timeout_flag[1]), 64'd0);
`else
    wait_trig(3000, id, lat, w);
    check("noto_id", 64'(id), 64'd1);
    v0 = vcnt;
    repeat (30000) @(negedge clk);
    check("noto_busy", 64'(busy), 64'd1);
    check("noto_noupd", 64'(vcnt), 64'(v0));
    check("noto_dist", 64'(distance_cm[31:16]), 64'd5);
`endif
    reset_p = 1'b1;
    enable_mask = 3'b111;
    @(negedge clk);
    reset_p = 1'b0;
    lat = 0;
    while (trig == '0 && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check("guard_latency", 64'(lat), 64'd1001);
    check("first_trig", 64'(trig), 64'd1);
    repeat (50) @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    check("rst_mid_trig", 64'(trig), 64'd0);
    check("rst_mid_dist", 64'(distance_cm), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_id", 64'(sensor_id), 64'd0);
    reset_p = 1'b0;
    wait_trig(3000, id, lat, w);
    check("restart_lat", 64'(lat), 64'd1001);
    check("restart_id", 64'(id), 64'd0);
    check("restart_width", 64'(w), 64'd120);
    push(0, 10, 1'b0);
    echo_pulse(0, 580);
    repeat (20) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("final_dist0", 64'(distance_cm[15:0]), 64'd10);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
